sn_stream_decoder: RTL and testbench

Stochastic-to-binary decoder that sits directly downstream of the stochastic multiplier stage. It counts the 1s in a serial stochastic bitstream over a programmable power-of-two window and publishes the unipolar count with a one-cycle done strobe. Optionally, it also publishes the bipolar value 2·count − L. It replaces the fixed 8-cycle free-running up-counter with a start/busy/done handshaked, window-exact converter.

---
 rtl/sn_stream_decoder_if.sv | 42 ++++
 rtl/sn_stream_decoder.sv | 168 ++++++++++++++++
 tb/tb_sn_stream_decoder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sn_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// sn_stream_decoder_if
//
// Bundles the sample stream, the start/continuous/window-select controls and
// the busy/done/count/bipolar results of the stochastic stream decoder.
//
//   sn_bit      stochastic bitstream bit
//   sn_valid    sn_bit carries a sample this cycle
//   start       level request to begin a window (ignored while busy)
//   continuous  sampled at window end; 1 = restart with no gap
//   win_sel     window exponent, L = 2^min(win_sel, MAX_LOG2)
//   busy        window in progress
//   done        one-cycle strobe, count/bipolar updated on the same cycle
//   count       ones in the last completed window (0..L)
//   bipolar     two's-complement 2*count - L of the last completed window
//
// master : the stream source / controller
// slave  : the decoder
// -----------------------------------------------------------------------------
interface sn_stream_decoder_if #(
  parameter int unsigned MAX_LOG2 = 8
);
  logic                  sn_bit;
  logic                  sn_valid;
  logic                  start;
  logic                  continuous;
  logic [3:0]            win_sel;
  logic                  busy;
  logic                  done;
  logic [MAX_LOG2:0]     count;
  logic [MAX_LOG2+1:0]   bipolar;

  modport master (
    output sn_bit, sn_valid, start, continuous, win_sel,
    input  busy, done, count, bipolar
  );

  modport slave (
    input  sn_bit, sn_valid, start, continuous, win_sel,
    output busy, done, count, bipolar
  );
endinterface

// File: rtl/sn_stream_decoder.sv
// -----------------------------------------------------------------------------
// sn_stream_decoder
//
// Stochastic-to-binary decoder. Counts the 1s of a serial stochastic bitstream
// over a window of L = 2^min(win_sel, MAX_LOG2) valid samples and publishes
// the unipolar count (and optionally the bipolar value 2*count - L) together
// with a one-cycle done strobe. A window is started by start (IDLE only) and
// can chain back-to-back when continuous is high at the window end.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; release is expected to be
//          synchronous to clk (driven from a reset synchroniser upstream)
//   bus    sn_stream_decoder_if.slave (stream in, control in, results out)
//
// Parameters:
//   MAX_LOG2  largest window exponent; maximum window 2^MAX_LOG2 samples
//
// Configuration macro:
//   SN_DEC_BIPOLAR_EN  when defined, bipolar is computed and registered on
//                      done; otherwise the port is tied to zero and no
//                      subtractor or register exists.
// -----------------------------------------------------------------------------
module sn_stream_decoder #(
  parameter int unsigned MAX_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sn_stream_decoder_if.slave   bus
);

  localparam int unsigned CNT_W = MAX_LOG2 + 1;
  localparam int unsigned BIP_W = MAX_LOG2 + 2;
  // Largest exponent that win_sel (4 bits) can express after clamping.
  localparam logic [3:0]  MAX_SEL = (MAX_LOG2 > 15) ? 4'd15 : 4'(MAX_LOG2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q,   state_d;
  logic [3:0]         l_exp_q,   l_exp_d;
  logic [CNT_W-1:0]   ones_q,    ones_d;
  logic [CNT_W-1:0]   samples_q, samples_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [CNT_W-1:0]   count_q,   count_d;
`ifdef SN_DEC_BIPOLAR_EN
  logic [BIP_W-1:0]   bipolar_q, bipolar_d;
`endif

  logic [3:0]         l_exp_sel;
  logic [CNT_W-1:0]   win_len;
  logic [CNT_W-1:0]   last_idx;
  logic [CNT_W-1:0]   ones_next;

  // Exponent to latch at a window start; out-of-range selects clamp to max.
  assign l_exp_sel = (bus.win_sel > MAX_SEL) ? MAX_SEL : bus.win_sel;

  // L = 2^l_exp fits in CNT_W bits, so L-1 is the index of the final sample.
  assign win_len   = CNT_W'(1) << l_exp_q;
  assign last_idx  = win_len - CNT_W'(1);

  // Running total including the current sample; used both to accumulate and
  // to publish the result so the final sample of a window is counted.
  assign ones_next = ones_q + CNT_W'(bus.sn_bit);

  // NOTE: every _d gets a hold/default value before the case statement, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    l_exp_d   = l_exp_q;
    ones_d    = ones_q;
    samples_d = samples_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    count_d   = count_q;
`ifdef SN_DEC_BIPOLAR_EN
    bipolar_d = bipolar_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          l_exp_d   = l_exp_sel;
          ones_d    = '0;
          samples_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        // start is deliberately not looked at here: it is neither honoured
        // nor remembered while a window is open.
        if (bus.sn_valid) begin
          if (samples_q == last_idx) begin
            count_d   = ones_next;
`ifdef SN_DEC_BIPOLAR_EN
            // 2*count - L; BIP_W bits hold the full range -L..+L.
            bipolar_d = {ones_next, 1'b0} - BIP_W'(win_len);
`endif
            done_d    = 1'b1;
            ones_d    = '0;
            samples_d = '0;
            if (bus.continuous) begin
              // Back-to-back window: next valid sample opens it, using the
              // window select present right now.
              l_exp_d = l_exp_sel;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            ones_d    = ones_next;
            samples_d = samples_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of order.
  // NOTE: all flops, including the accumulators, are reset; a reset in the
  // middle of a window must discard it without ever producing a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      l_exp_q   <= '0;
      ones_q    <= '0;
      samples_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
`ifdef SN_DEC_BIPOLAR_EN
      bipolar_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      l_exp_q   <= l_exp_d;
      ones_q    <= ones_d;
      samples_q <= samples_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
`ifdef SN_DEC_BIPOLAR_EN
      bipolar_q <= bipolar_d;
`endif
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;
`ifdef SN_DEC_BIPOLAR_EN
  assign bus.bipolar = bipolar_q;
`else
  assign bus.bipolar = '0;
`endif

endmodule

// File: tb/tb_sn_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_sn_stream_decoder
//
// Self-checking bench for sn_stream_decoder. Inputs are driven on the falling
// edge; a queue-based reference model of the window rules advances on each
// rising edge and the DUT outputs are compared on the following falling edge.
// Directed scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_sn_stream_decoder;

  localparam int MAX_LOG2 = 8;
`ifdef SN_DEC_BIPOLAR_EN
  localparam bit BIP_EN = 1'b1;
`else
  localparam bit BIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sn_stream_decoder_if #(.MAX_LOG2(MAX_LOG2)) dif ();

  sn_stream_decoder #(.MAX_LOG2(MAX_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  bit m_run   = 1'b0;
  int m_len   = 1;
  int m_bits[$];
  int m_busy  = 0;
  int m_done  = 0;
  int m_count = 0;
  int m_bip   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int win_len(input logic [3:0] ws);
    int e;
    e = (int'(ws) > MAX_LOG2) ? MAX_LOG2 : int'(ws);
    return 1 << e;
  endfunction

  function automatic int bip_of(input int ones, input int len);
    return BIP_EN ? (2 * ones - len) : 0;
  endfunction

  function automatic int dut_bip();
    return int'($signed(dif.bipolar));
  endfunction

  task automatic drive(input bit s, input bit v, input bit b, input bit c,
                       input logic [3:0] ws);
    dif.start      = s;
    dif.sn_valid   = v;
    dif.sn_bit     = b;
    dif.continuous = c;
    dif.win_sel    = ws;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    int ones;
    m_done = 0;
    if (!m_run) begin
      if (dif.start) begin
        m_run  = 1'b1;
        m_busy = 1;
        m_len  = win_len(dif.win_sel);
        m_bits.delete();
      end
    end else if (dif.sn_valid) begin
      m_bits.push_back(int'(dif.sn_bit));
      if (m_bits.size() == m_len) begin
        ones = 0;
        foreach (m_bits[i]) ones += m_bits[i];
        m_count = ones;
        m_bip   = bip_of(ones, m_len);
        m_done  = 1;
        m_bits.delete();
        if (dif.continuous) begin
          m_len = win_len(dif.win_sel);
        end else begin
          m_run  = 1'b0;
          m_busy = 0;
        end
      end
    end
  endtask

  // One clock: model advances at the rising edge, DUT checked at the falling.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check("busy",    int'(dif.busy),  m_busy);
    check("done",    int'(dif.done),  m_done);
    check("count",   int'(dif.count), m_count);
    check("bipolar", dut_bip(),       m_bip);
  endtask

  // Asynchronous reset in the middle of a cycle; released on a falling edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy",    int'(dif.busy),  0);
    check("rst_done",    int'(dif.done),  0);
    check("rst_count",   int'(dif.count), 0);
    check("rst_bipolar", dut_bip(),       0);
    m_run = 1'b0; m_busy = 0; m_done = 0; m_count = 0; m_bip = 0;
    m_bits.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int dones;
    int ones;
    bit pat[4];
    bit rb[8];

    drive(0, 0, 0, 0, 4'd0);
    #1;
    check("init_busy",  int'(dif.busy),  0);
    check("init_done",  int'(dif.done),  0);
    check("init_count", int'(dif.count), 0);
    check("init_bip",   dut_bip(),       0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Single-shot, all ones, L=8 (start-cycle sample is not counted)
    drive(1, 1, 1, 0, 4'd3);
    cycle();
    check("ss_busy_rise", int'(dif.busy), 1);
    drive(0, 1, 1, 0, 4'd3);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      cycle();
      if (dif.done) lat = i;
    end
    check("ss_latency", lat, 8);
    check("ss_count",   int'(dif.count), 8);
    check("ss_bipolar", dut_bip(), BIP_EN ? 8 : 0);
    check("ss_busy_at_done", int'(dif.busy), 0);
    cycle();
    check("ss_busy_after", int'(dif.busy), 0);

    // Reset at sample 5 of an L=16 window: no done afterwards
    drive(1, 1, 1, 0, 4'd4);
    cycle();
    drive(0, 1, 1, 0, 4'd4);
    repeat (5) cycle();
    async_reset();
    drive(0, 1, 1, 0, 4'd4);
    dones = 0;
    repeat (20) begin
      cycle();
      dones += int'(dif.done);
    end
    check("rst_no_done", dones, 0);

    // Gapped valid, L=4, bits 1,0,1,1 on the valid cycles
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive(1, 0, 0, 0, 4'd2);
    cycle();
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      bit v;
      v = (i % 2) == 1;
      drive(0, v, v ? pat[i/2] : 1'($urandom), 0, 4'd2);
      cycle();
      if (dif.done && lat < 0) lat = i + 1;
    end
    check("gap_latency", lat, 8);
    check("gap_count",   int'(dif.count), 3);
    check("gap_bipolar", dut_bip(), BIP_EN ? 2 : 0);

    // Continuous, L=2, alternating 1,0
    drive(1, 1, 1, 1, 4'd1);
    cycle();
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, (i % 2) == 0, 1, 4'd1);
      cycle();
      if (dif.done) begin
        dones++;
        check("cont_count",   int'(dif.count), 1);
        check("cont_bipolar", dut_bip(), 0);
      end
      check("cont_busy", int'(dif.busy), 1);
    end
    check("cont_dones", dones, 3);
    // win_sel -> 3 mid-window: current window keeps L=2, next is L=8
    drive(0, 1, 1, 1, 4'd1);
    cycle();
    drive(0, 1, 0, 1, 4'd3);
    cycle();
    check("cont_l2_kept", int'(dif.done), 1);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      drive(0, 1, (i % 2) == 0, 0, 4'd3);
      cycle();
      if (dif.done) lat = i + 1;
    end
    check("cont_l8_latency", lat, 8);
    check("cont_l8_count",   int'(dif.count), 4);
    check("cont_l8_bipolar", dut_bip(), 0);
    check("cont_l8_busy",    int'(dif.busy), 0);

    // L=1 with a zero sample
    drive(1, 1, 1, 0, 4'd0);
    cycle();
    drive(0, 1, 0, 0, 4'd0);
    cycle();
    check("l1_done",    int'(dif.done),  1);
    check("l1_count",   int'(dif.count), 0);
    check("l1_bipolar", dut_bip(), BIP_EN ? -1 : 0);
    check("l1_busy",    int'(dif.busy),  0);

    // Clamp: win_sel=15 -> 256 samples, all zero
    drive(1, 1, 0, 0, 4'd15);
    cycle();
    drive(0, 1, 0, 0, 4'd15);
    lat = -1;
    for (int i = 1; i <= 300 && lat < 0; i++) begin
      cycle();
      if (dif.done) lat = i;
    end
    check("clamp_latency", lat, 256);
    check("clamp_count",   int'(dif.count), 0);
    check("clamp_bipolar", dut_bip(), BIP_EN ? -256 : 0);

    // start pulsed at sample 3 of L=8 is ignored
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      rb[i] = 1'($urandom);
      ones += int'(rb[i]);
    end
    drive(1, 1, 0, 0, 4'd3);
    cycle();
    dones = 0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      drive(i == 2, 1, (i < 8) ? rb[i] : 1'($urandom), 0, 4'd3);
      cycle();
      if (dif.done) begin
        dones++;
        if (lat < 0) lat = i + 1;
      end
    end
    check("sb_dones",   dones, 1);
    check("sb_latency", lat,   8);
    check("sb_count",   int'(dif.count), ones);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 6000; i++) begin
      logic [3:0] ws;
      ws = ($urandom % 10 == 0) ? 4'($urandom % 16) : 4'($urandom % 4);
      drive(($urandom % 8) == 0, ($urandom % 4) != 0, 1'($urandom),
            ($urandom % 3) == 0, ws);
      if ($urandom % 700 == 0) async_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
